// File: rtl/click_if.sv
// Press-pulse input and classified click events exchanged between the button
// stage, the classifier and the mode/control logic.
interface click_if;
  logic in_pulse;
  logic single_click;
  logic double_click;
  logic triple_click;
  logic busy;

  modport master (
    output in_pulse,
    input  single_click,
    input  double_click,
    input  triple_click,
    input  busy
  );

  modport slave (
    input  in_pulse,
    output single_click,
    output double_click,
    output triple_click,
    output busy
  );
endinterface

// File: rtl/click_classifier.sv
// Groups debounced press pulses inside a sliding window and emits one single-cycle
// click event per group. Optional macro TRIPLE_CLICK_EN adds triple-click detection.
//
//   state | meaning
//   IDLE  | no group open, waiting for a press
//   ONE   | one press seen, window running
//   TWO   | two presses seen, window running (TRIPLE_CLICK_EN only)
module click_classifier #(
  parameter int WINDOW = 40,
  parameter int CNT_W  = 6
) (
  input  logic   clk,
  input  logic   rst_n,
  click_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef TRIPLE_CLICK_EN
    ONE  = 2'd1,
    TWO  = 2'd2
`else
    ONE  = 2'd1
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press, timeout;
  logic             single_nxt, double_nxt;
  logic             single_q, double_q, busy_q;
`ifdef TRIPLE_CLICK_EN
  logic             triple_nxt, triple_q;
`endif

  assign press   = bus.in_pulse;
  assign timeout = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
`ifdef TRIPLE_CLICK_EN
      triple_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      single_q <= single_nxt;
      double_q <= double_nxt;
      busy_q   <= (state_nxt != IDLE);
`ifdef TRIPLE_CLICK_EN
      triple_q <= triple_nxt;
`endif
    end
  end

  // A press always takes priority over a timeout landing on the same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (press) begin
          state_nxt = ONE;
          cnt_nxt   = '0;
        end
      end
      ONE: begin
        if (press) begin
`ifdef TRIPLE_CLICK_EN
          state_nxt = TWO;
`else
          state_nxt = IDLE;
`endif
          cnt_nxt   = '0;
        end else if (timeout) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
`ifdef TRIPLE_CLICK_EN
      TWO: begin
        if (press || timeout) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    single_nxt = 1'b0;
    double_nxt = 1'b0;
`ifdef TRIPLE_CLICK_EN
    triple_nxt = 1'b0;
`endif
    case (state)
      ONE: begin
        if (!press && timeout) single_nxt = 1'b1;
`ifndef TRIPLE_CLICK_EN
        if (press) double_nxt = 1'b1;
`endif
      end
`ifdef TRIPLE_CLICK_EN
      TWO: begin
        if (press)        triple_nxt = 1'b1;
        else if (timeout) double_nxt = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.single_click = single_q;
  assign bus.double_click = double_q;
  assign bus.busy         = busy_q;
`ifdef TRIPLE_CLICK_EN
  assign bus.triple_click = triple_q;
`else
  assign bus.triple_click = 1'b0;
`endif

endmodule

// File: tb/tb_click_classifier.sv
// Bench for click_classifier: directed table, reset-in-group sequence and random
// pulses checked every cycle against a press-timestamp model.
module tb_click_classifier;

  localparam int WINDOW = 8;
  localparam int CNT_W  = 3;
`ifdef TRIPLE_CLICK_EN
  localparam int MAX_PRESS = 3;
`else
  localparam int MAX_PRESS = 2;
`endif

  logic clk;
  logic rst_n;
  click_if bus ();

  click_classifier #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int edge_no  = 0;
  int m_n      = 0;
  int m_tlast  = 0;

  typedef struct {
    int p0, p1, p2;
    int ev1, e1;
    int ev2, e2;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a group is a press count plus the time of its latest press.
  task automatic model_step(input bit p, output logic [3:0] exp);
    int evt;
    evt = 0;
    if (m_n == 0) begin
      if (p) begin
        m_n = 1;
        m_tlast = cyc;
      end
    end else if (p) begin
      m_n++;
      if (m_n == MAX_PRESS) begin
        evt = m_n;
        m_n = 0;
      end else begin
        m_tlast = cyc;
      end
    end else if (cyc - m_tlast == WINDOW) begin
      evt = m_n;
      m_n = 0;
    end
    exp = {evt == 3, evt == 2, evt == 1, m_n != 0};
  endtask

  function automatic logic [3:0] dut_out();
    return {bus.triple_click, bus.double_click, bus.single_click, bus.busy};
  endfunction

  function automatic int ev_code(input logic [3:0] o);
    return o[3] ? 3 : o[2] ? 2 : o[1] ? 1 : 0;
  endfunction

  task automatic run_cycle(input bit p, output int code);
    logic [3:0] exp, got;
    bus.in_pulse = p;
    @(posedge clk);
    cyc++;
    edge_no++;
    model_step(p, exp);
    #1;
    got = dut_out();
    check($sformatf("cyc%0d_edge%0d", cyc, edge_no), int'(got), int'(exp));
    code = ev_code(got);
    bus.in_pulse = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_pulse = 1'b0;
    rst_n = 1'b0;
    m_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", int'(dut_out()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_no = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int code, n_ev, got_ev[2], got_e[2];
    n_ev = 0;
    got_ev[0] = 0; got_ev[1] = 0; got_e[0] = -1; got_e[1] = -1;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      run_cycle(e == v.p0 || e == v.p1 || e == v.p2, code);
      if (code != 0 && n_ev < 2) begin
        got_ev[n_ev] = code;
        got_e[n_ev]  = e;
        n_ev++;
      end
    end
    check($sformatf("vec%0d_ev1_type", idx), got_ev[0], v.ev1);
    check($sformatf("vec%0d_ev1_edge", idx), got_e[0], v.e1);
    check($sformatf("vec%0d_ev2_type", idx), got_ev[1], v.ev2);
    check($sformatf("vec%0d_ev2_edge", idx), got_e[1], v.e2);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int code, first_ev, first_e, thresh;
    rst_n = 1'b0;
    bus.in_pulse = 1'b0;

    // {press edges, first event type/edge, second event type/edge}; type 1/2/3 = single/double/triple
`ifdef TRIPLE_CLICK_EN
    vecs[0] = '{10, -1, -1, 1, 18, 0, -1};
    vecs[1] = '{10, 12, 15, 3, 15, 0, -1};
    vecs[2] = '{10, 12, -1, 2, 20, 0, -1};
    vecs[3] = '{10, 18, 26, 3, 26, 0, -1};
    vecs[4] = '{10, 19, -1, 1, 18, 1, 27};
    vecs[5] = '{10, 13, 14, 3, 14, 0, -1};
`else
    vecs[0] = '{10, -1, -1, 1, 18, 0, -1};
    vecs[1] = '{10, 13, -1, 2, 13, 0, -1};
    vecs[2] = '{10, 18, -1, 2, 18, 0, -1};
    vecs[3] = '{10, 19, -1, 1, 18, 1, 27};
    vecs[4] = '{10, 11, -1, 2, 11, 0, -1};
    vecs[5] = '{10, 13, 14, 2, 13, 1, 22};
`endif

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset in the middle of an open group.
    do_reset();
    for (int e = 1; e <= 12; e++) run_cycle(e == 10, code);
    #2;
    rst_n = 1'b0;
    m_n = 0;
    #1;
    check("async_reset_outputs", int'(dut_out()), 0);
    run_cycle(1'b0, code);
    run_cycle(1'b0, code);
    rst_n = 1'b1;
    first_ev = 0;
    first_e  = -1;
    for (int e = 15; e <= 32; e++) begin
      run_cycle(e == 20, code);
      if (code != 0 && first_ev == 0) begin
        first_ev = code;
        first_e  = e;
      end
    end
    check("rst_mid_group_ev_type", first_ev, 1);
    check("rst_mid_group_ev_edge", first_e, 28);

    // Random pulse trains of varying density.
    do_reset();
    for (int blk = 0; blk < 10; blk++) begin
      thresh = $urandom_range(1, 8);
      for (int k = 0; k < 300; k++)
        run_cycle($urandom_range(0, 15) < thresh, code);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
